amplificador_param: RTL and testbench

AMPLIFICADOR_PARAM -- requirements
Module: amplificador_param

---
 rtl/amplificador_param.sv | 121 ++++++++++++
 tb/tb_amplificador_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/amplificador_param.sv
// rtl/amplificador_param.sv - two-stage signed x unsigned gain stage with saturation and bypass
// Stage 1 holds the full product, stage 2 holds the shifted and clamped result.
module amplificador_param #(
  parameter int WIDTH  = 8,
  parameter int GAIN_W = 4,
  parameter int FRAC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [GAIN_W-1:0] in_gain,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_sat,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
);

  localparam int PW = WIDTH + GAIN_W + 1;
  typedef logic signed [PW-1:0] prod_t;

  localparam prod_t MAX_V = {{(GAIN_W+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam prod_t MIN_V = {{(GAIN_W+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic             s1_valid_q;
  prod_t            s1_prod_q;
  logic             s1_bypass_q;
  logic [WIDTH-1:0] s1_data_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_sat_q;
  logic [15:0]      sat_count_q;

  logic             s2_adv;
  logic             s1_take;
  logic             in_xfer;
  logic             out_xfer;
  prod_t            data_ext;
  prod_t            gain_ext;
  prod_t            prod_d;
  prod_t            shifted;
  logic [WIDTH-1:0] out_data_d;
  logic             out_sat_d;
  logic [15:0]      sat_count_d;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_take  = !s1_valid_q || s2_adv;
  assign in_ready = rst_n && s1_take;
  assign in_xfer  = in_valid && s1_take;
  assign out_xfer = out_valid_q && out_ready;

  // Both operands widened to the product width so the product cannot overflow.
  assign data_ext = {{(GAIN_W+1){in_data[WIDTH-1]}}, in_data};
  assign gain_ext = {{(WIDTH+1){1'b0}}, in_gain};
  assign prod_d   = data_ext * gain_ext;
  assign shifted  = s1_prod_q >>> FRAC;

  always_comb begin
    out_data_d = shifted[WIDTH-1:0];
    out_sat_d  = 1'b0;
    if (s1_bypass_q) begin
      out_data_d = s1_data_q;
    end else if (shifted > MAX_V) begin
      out_data_d = MAX_V[WIDTH-1:0];
      out_sat_d  = 1'b1;
    end else if (shifted < MIN_V) begin
      out_data_d = MIN_V[WIDTH-1:0];
      out_sat_d  = 1'b1;
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = 16'd0;
    end else if (out_xfer && out_sat_q && sat_count_q != 16'hFFFF) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_bypass_q <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= 16'd0;
    end else begin
      if (s1_take) begin
        s1_valid_q <= in_valid;
      end
      if (in_xfer) begin
        s1_prod_q   <= prod_d;
        s1_bypass_q <= in_bypass;
        s1_data_q   <= in_data;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= out_data_d;
          out_sat_q  <= out_sat_d;
        end
      end
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_amplificador_param.sv
// tb/tb_amplificador_param.sv - directed checks of amplificador_param (WIDTH=8, GAIN_W=4, FRAC=2)
module tb_amplificador_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_gain;
  logic       in_bypass;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic       sat_clr;
  logic [15:0] sat_count;

  int tests = 0;
  int fails = 0;

  amplificador_param #(.WIDTH(8), .GAIN_W(4), .FRAC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_gain   (in_gain),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [7:0] d, input logic [3:0] g, input logic b);
    in_valid  = 1'b1;
    in_data   = d;
    in_gain   = g;
    in_bypass = b;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_gain = '0; in_bypass = 1'b0;
    out_ready = 1'b1; sat_clr = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_in_ready", in_ready, 1);

    // 20 * 6 / 4 = 30
    @(negedge clk); present(8'd20, 4'd6, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    @(negedge clk);
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 8'd30);
    check("basic_sat", out_sat, 0);
    check("basic_cnt", sat_count, 0);

    // back-to-back saturation, positive and negative
    @(negedge clk); present(8'd100, 4'd15, 1'b0);
    @(negedge clk); present(8'h9C, 4'd15, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("satp_valid", out_valid, 1);
    check("satp_data", out_data, 8'h7F);
    check("satp_sat", out_sat, 1);
    @(negedge clk);
    check("satn_valid", out_valid, 1);
    check("satn_data", out_data, 8'h80);
    check("satn_sat", out_sat, 1);
    check("sat_cnt_1", sat_count, 1);
    @(negedge clk);
    check("sat_cnt_2", sat_count, 2);
    check("sat_drain", out_valid, 0);

    // -5 * 1 / 4 floors to -2; bypass passes 100 untouched
    @(negedge clk); present(8'hFB, 4'd1, 1'b0);
    @(negedge clk); present(8'd100, 4'd15, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    check("floor_data", out_data, 8'hFE);
    check("floor_sat", out_sat, 0);
    @(negedge clk);
    check("byp_valid", out_valid, 1);
    check("byp_data", out_data, 8'd100);
    check("byp_sat", out_sat, 0);
    @(negedge clk);
    check("byp_cnt", sat_count, 2);

    // backpressure: three samples offered with out_ready low
    out_ready = 1'b0;
    present(8'd10, 4'd4, 1'b0);
    #1 check("bp_rdy_a", in_ready, 1);
    @(negedge clk); present(8'hF8, 4'd4, 1'b0);
    check("bp_rdy_b", in_ready, 1);
    @(negedge clk); present(8'd20, 4'd4, 1'b0);
    check("bp_rdy_c", in_ready, 0);
    check("bp_hold_v", out_valid, 1);
    check("bp_hold_d0", out_data, 8'd10);
    @(negedge clk);
    check("bp_rdy_c2", in_ready, 0);
    check("bp_hold_d1", out_data, 8'd10);
    out_ready = 1'b1;
    #1 check("bp_rdy_release", in_ready, 1);
    @(negedge clk); in_valid = 1'b0;
    check("bp_out_b_v", out_valid, 1);
    check("bp_out_b", out_data, 8'hF8);
    @(negedge clk);
    check("bp_out_c_v", out_valid, 1);
    check("bp_out_c", out_data, 8'd20);
    @(negedge clk);
    check("bp_empty", out_valid, 0);

    // drive sat_count from 2 up to its ceiling
    present(8'd100, 4'd15, 1'b0);
    repeat (65533) @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cnt_full", sat_count, 16'hFFFF);
    present(8'd100, 4'd15, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("cnt_extra_sat", out_sat, 1);
    @(negedge clk);
    check("cnt_no_wrap", sat_count, 16'hFFFF);

    // clear beats increment
    present(8'h9C, 4'd15, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("clr_sat_v", out_valid & out_sat, 1);
    sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    check("clr_wins", sat_count, 0);

    // asynchronous reset with two samples in flight
    present(8'd20, 4'd6, 1'b0);
    @(negedge clk); present(8'd40, 4'd4, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("inflight_v", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("arst_stale0", out_valid, 0);
    @(negedge clk);
    check("arst_stale1", out_valid, 0);

    // first sample after reset follows normal latency
    present(8'd20, 4'd6, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("re_lat", out_valid, 0);
    @(negedge clk);
    check("re_valid", out_valid, 1);
    check("re_data", out_data, 8'd30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
